branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch/jump resolution stage with a 2-bit-counter branch history table (BHT). It sits at the end of execute. It resolves the branch and jump opcodes issued by control, checks them against the direction predicted at fetch, and drives a registered redirect to fetch. It also trains the BHT, and fetch reads the BHT combinationally for its next prediction.

## Interface
- XLEN, 32: datapath/PC width (≥ 8)
- BHT_IDX, 6: log2 of BHT entries; index = PC[BHT_IDX+1:2]
- CNT_W, 32: width of performance counters
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  resolve request this cycle
- ex_flush  in  1  kill request presented this cycle
- ex_op  in  5  branch opcode from control
- ex_target  in  XLEN-6  absolute jump field from instruction
- ex_imm  in  XLEN  signed word offset
- ex_d0, ex_d1  in  XLEN  signed register operands
- ex_pc  in  XLEN  PC of the branch
- ex_pred_taken  in  1  direction fetch predicted for this branch
- if_pc  in  XLEN  fetch PC for lookup
- if_pred_taken  out  1  BHT[if_pc] MSB, combinational
- res_valid  out  1  result strobe, one cycle
- res_taken  out  1  resolved direction
- res_pc  out  XLEN  resolved next PC (target or ex_pc+4)
- redirect  out  1  fetch must restart at res_pc
- br_count, mis_count  out  CNT_W  conditional branches resolved / mispredicted

## Operation
- Opcodes. The first six entries are conditional; D0 and D1 are compared signed.
  - 10001 BEQ: taken if D0==D1
  - 10010 BNE: taken if D0!=D1
  - 00010 BGEZ: taken if D0≥0
  - 00011 BGTZ: taken if D0>0
  - 00100 BLTZ: taken if D0<0
  - 00101 BLEZ: taken if D0≤0
  - 00001 BAL: unconditional, taken
  - 00111 J: unconditional, taken
  - 01000 JR: unconditional, taken
  - Any other opcode: not a branch. res_valid=0, no state change.
- Targets. All arithmetic is modulo 2^XLEN.
  - PC-relative: ex_pc + (ex_imm<<2).
  - J: {ex_pc[XLEN-1:XLEN-4], ex_target, 2'b00}.
  - JR: ex_d0.
  - Fall-through: ex_pc+4.
- Redirect rules.
  - Conditional: redirect = res_taken XOR ex_pred_taken.
  - Unconditional: redirect=1 always; ex_pred_taken is ignored.
- BHT.
  - 2^BHT_IDX entries of 2-bit saturating counters. Reset value is 01 (weakly not-taken).
  - Each accepted conditional branch updates the entry at ex_pc[BHT_IDX+1:2]: increment if taken, saturate at 11; decrement if not taken, saturate at 00.
  - Unconditional branches never update the BHT.
- Perf counters.
  - br_count increments on every accepted conditional branch.
  - mis_count increments on every accepted conditional branch with redirect=1.
  - Both saturate at all-ones. Neither is reset by ex_flush.
- Accepted means ex_valid=1 and ex_flush=0 at the clock edge.

## Timing
- Request is sampled on the rising edge. res_valid, res_taken, res_pc and redirect are registered: latency 1 cycle, held for exactly 1 cycle, all 0 otherwise.
- BHT and counter updates happen on the same edge that samples the request.
- Back-to-back requests are accepted every cycle; there is no stall or backpressure.
- ex_flush with ex_valid on the same edge: the request is dropped. No result, no BHT or counter update.
- Lookup and update of the same index in one cycle: if_pred_taken shows the pre-update value; the new value is visible next cycle.
- Reset (rst_n=0 at an edge), including mid-stream: all outputs go to 0, every BHT entry to 01, counters to 0. Any request sampled on that edge is lost.

## Test plan
- Reset, then BEQ at ex_pc=0x100, imm=4, d0=d1=5, pred=0.
  - Cycle+1: res_valid=1, res_taken=1, res_pc=0x110, redirect=1.
  - BHT[0] becomes 10; br_count=1, mis_count=1.
- BHT training at PC 0x200, starting from reset value 01.
  - Four taken BGTZ (d0=3): if_pred_taken at if_pc=0x200 becomes 1 after the first update and the counter saturates at 11.
  - Three not-taken BGTZ (d0=-1): the entry goes 11→10→01→00 and if_pred_taken returns to 0.
- Fall-through edge values.
  - BLTZ with d0=0x80000000, pc=0xFFFFFFFC, pred=1: taken, no redirect.
  - BLEZ with d0=1, pred=1, pc=0xFFFFFFFC: res_pc=0x00000000 (wrap), redirect=1.
- Unconditional jumps.
  - J with pc=0xA0000010, target=0x0000400: res_pc=0xA0001000, redirect=1 even with pred=1, BHT unchanged.
  - JR with d0=0x1234: res_pc=0x1234, redirect=1.
- ex_flush together with a BEQ request: no res_valid, BHT and br_count unchanged.
  - Opcode 11111 presented: no res_valid.
- rst_n low for one edge while a request is presented: all outputs and counters are 0 next cycle, and BHT reads 01 at any if_pc.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Branch resolve request/result bundle between execute and resolve.
// master: drives ex_* and reads res_*; slave: the inverse.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_flush;
  logic [4:0]      ex_op;
  logic [XLEN-7:0] ex_target;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_d0;
  logic [XLEN-1:0] ex_d1;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            res_valid;
  logic            res_taken;
  logic [XLEN-1:0] res_pc;
  logic            redirect;

  modport master (
    output ex_valid, ex_flush, ex_op,
    output ex_target, ex_imm, ex_d0,
    output ex_d1, ex_pc, ex_pred_taken,
    input  res_valid, res_taken,
    input  res_pc, redirect
  );

  modport slave (
    input  ex_valid, ex_flush, ex_op,
    input  ex_target, ex_imm, ex_d0,
    input  ex_d1, ex_pc, ex_pred_taken,
    output res_valid, res_taken,
    output res_pc, redirect
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution with 2-bit BHT and perf counters.
// Ports: clk, rst_n, ex (request/result bundle), if_pc/if_pred_taken, br_count, mis_count.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int BHT_IDX = 6,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_resolve_unit_if.slave ex,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int NENT = 1 << BHT_IDX;

  localparam logic [4:0] OP_BEQ  = 5'b10001;
  localparam logic [4:0] OP_BNE  = 5'b10010;
  localparam logic [4:0] OP_BGEZ = 5'b00010;
  localparam logic [4:0] OP_BGTZ = 5'b00011;
  localparam logic [4:0] OP_BLTZ = 5'b00100;
  localparam logic [4:0] OP_BLEZ = 5'b00101;
  localparam logic [4:0] OP_BAL  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00111;
  localparam logic [4:0] OP_JR   = 5'b01000;

  logic [1:0] bht [NENT];

  logic [BHT_IDX-1:0] ex_idx;
  logic [BHT_IDX-1:0] if_idx;
  logic [XLEN-1:0]    rel;
  logic [XLEN-1:0]    seq;
  logic [XLEN-1:0]    jabs;
  logic [XLEN-1:0]    tgt;
  logic [XLEN-1:0]    npc;
  logic               eq;
  logic               neg;
  logic               zero;
  logic               is_cond;
  logic               is_unc;
  logic               taken;
  logic               redir;
  logic               acc;
  logic [1:0]         cur;
  logic [1:0]         upd;
  logic               unused_pc;

  assign ex_idx = ex.ex_pc[BHT_IDX+1:2];
  assign if_idx = if_pc[BHT_IDX+1:2];
  assign unused_pc = ^{if_pc[XLEN-1:BHT_IDX+2],
                       if_pc[1:0]};

  assign if_pred_taken = bht[if_idx][1];

  assign rel  = ex.ex_pc + (ex.ex_imm << 2);
  assign seq  = ex.ex_pc + XLEN'(4);
  assign jabs = {ex.ex_pc[XLEN-1:XLEN-4],
                 ex.ex_target, 2'b00};

  assign eq   = ex.ex_d0 == ex.ex_d1;
  assign neg  = ex.ex_d0[XLEN-1];
  assign zero = ex.ex_d0 == '0;

  always_comb begin
    is_cond = 1'b0;
    is_unc  = 1'b0;
    taken   = 1'b0;
    tgt     = rel;
    unique case (ex.ex_op)
      OP_BEQ:  begin is_cond = 1'b1; taken = eq; end
      OP_BNE:  begin is_cond = 1'b1; taken = !eq; end
      OP_BGEZ: begin is_cond = 1'b1; taken = !neg; end
      OP_BGTZ: begin
        is_cond = 1'b1;
        taken   = !neg && !zero;
      end
      OP_BLTZ: begin is_cond = 1'b1; taken = neg; end
      OP_BLEZ: begin
        is_cond = 1'b1;
        taken   = neg || zero;
      end
      OP_BAL:  begin is_unc = 1'b1; taken = 1'b1; end
      OP_J:    begin
        is_unc = 1'b1;
        taken  = 1'b1;
        tgt    = jabs;
      end
      OP_JR:   begin
        is_unc = 1'b1;
        taken  = 1'b1;
        tgt    = ex.ex_d0;
      end
      default: ;
    endcase
  end

  assign npc   = taken ? tgt : seq;
  assign redir = is_unc | (taken ^ ex.ex_pred_taken);
  assign acc   = ex.ex_valid && !ex.ex_flush &&
                 (is_cond || is_unc);

  // Saturating 2-bit counter step for the entry being trained
  always_comb begin
    cur = bht[ex_idx];
    upd = cur;
    if (taken) begin
      if (cur != 2'b11) upd = cur + 2'd1;
    end else begin
      if (cur != 2'b00) upd = cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex.res_valid <= 1'b0;
      ex.res_taken <= 1'b0;
      ex.res_pc    <= '0;
      ex.redirect  <= 1'b0;
      br_count     <= '0;
      mis_count    <= '0;
      for (int i = 0; i < NENT; i++)
        bht[i] <= 2'b01;
    end else begin
      ex.res_valid <= acc;
      ex.res_taken <= acc && taken;
      ex.res_pc    <= acc ? npc : '0;
      ex.redirect  <= acc && redir;
      if (acc && is_cond) begin
        bht[ex_idx] <= upd;
        if (br_count != '1)
          br_count <= br_count + CNT_W'(1);
        if (redir && mis_count != '1)
          mis_count <= mis_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit.
// Table vectors plus hand sequences for BHT training and reset.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] br_count;
  logic [31:0] mis_count;

  int errors = 0;
  int checks = 0;

  branch_resolve_unit_if #(.XLEN(32)) bus();

  branch_resolve_unit #(
    .XLEN(32), .BHT_IDX(6), .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex(bus.slave),
    .if_pc(if_pc),
    .if_pred_taken(if_pred_taken),
    .br_count(br_count),
    .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        flush;
    logic [4:0]  op;
    logic [25:0] target;
    logic [31:0] imm;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] pc;
    logic        pred;
    logic        e_valid;
    logic        e_taken;
    logic [31:0] e_pc;
    logic        e_redir;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.ex_valid      = 1'b0;
    bus.ex_flush      = 1'b0;
    bus.ex_op         = 5'b0;
    bus.ex_target     = '0;
    bus.ex_imm        = '0;
    bus.ex_d0         = '0;
    bus.ex_d1         = '0;
    bus.ex_pc         = '0;
    bus.ex_pred_taken = 1'b0;
  endtask

  task automatic req(input logic [4:0] op,
                     input logic [25:0] tg,
                     input logic [31:0] imm,
                     input logic [31:0] d0,
                     input logic [31:0] d1,
                     input logic [31:0] pc,
                     input logic pred,
                     input logic fl);
    bus.ex_valid      = 1'b1;
    bus.ex_flush      = fl;
    bus.ex_op         = op;
    bus.ex_target     = tg;
    bus.ex_imm        = imm;
    bus.ex_d0         = d0;
    bus.ex_d1         = d1;
    bus.ex_pc         = pc;
    bus.ex_pred_taken = pred;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_res(input string nm,
                         input logic v,
                         input logic t,
                         input logic [31:0] p,
                         input logic r);
    chk({nm, ".valid"}, 32'(bus.res_valid), 32'(v));
    chk({nm, ".taken"}, 32'(bus.res_taken), 32'(t));
    chk({nm, ".pc"}, bus.res_pc, p);
    chk({nm, ".redir"}, 32'(bus.redirect), 32'(r));
  endtask

  vec_t tbl [11];
  int   e_br;
  int   e_mis;
  logic exp_p;
  logic [31:0] pcs [3];

  initial begin
    if_pc = '0;
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk_res("rst", 0, 0, 32'h0, 0);
    chk("rst.br", br_count, 0);
    chk("rst.mis", mis_count, 0);
    chk("rst.pred", 32'(if_pred_taken), 0);

    // First BEQ after reset
    req(5'b10001, '0, 32'd4, 32'd5, 32'd5,
        32'h100, 1'b0, 1'b0);
    tick();
    idle();
    chk_res("beq0", 1, 1, 32'h110, 1);
    if_pc = 32'h100;
    #1;
    chk("beq0.bht", 32'(if_pred_taken), 1);
    chk("beq0.br", br_count, 1);
    chk("beq0.mis", mis_count, 1);
    tick();
    chk_res("beq0.gap", 0, 0, 32'h0, 0);

    // BHT training at 0x200 from weakly not-taken
    do_reset();
    if_pc = 32'h200;
    for (int i = 0; i < 11; i++) begin
      logic tk;
      logic bef;
      logic aft;
      // sequence: T T T T N N N N T T (+1 idle)
      tk  = (i < 4) || (i == 8) || (i == 9);
      bef = (i >= 1 && i <= 5) || (i == 10);
      aft = (i <= 4) || (i == 9);
      if (i == 10) begin
        idle();
      end else begin
        req(5'b00011, '0, 32'd1,
            tk ? 32'd3 : 32'hFFFF_FFFF, '0,
            32'h200, 1'b0, 1'b0);
      end
      #1;
      chk($sformatf("train%0d.pre", i),
          32'(if_pred_taken), 32'(bef));
      if (i < 10) begin
        tick();
        chk($sformatf("train%0d.post", i),
            32'(if_pred_taken), 32'(aft));
      end
    end

    // Directed table, back-to-back
    do_reset();
    tbl[0]  = '{"bltz_min", 0, 5'b00100, '0, 32'd8,
                32'h8000_0000, 0, 32'hFFFF_FFFC, 1,
                1, 1, 32'h0000_001C, 0};
    tbl[1]  = '{"blez_wrap", 0, 5'b00101, '0, 32'd8,
                32'd1, 0, 32'hFFFF_FFFC, 1,
                1, 0, 32'h0000_0000, 1};
    tbl[2]  = '{"j_abs", 0, 5'b00111, 26'h400, 0,
                0, 0, 32'hA000_0010, 1,
                1, 1, 32'hA000_1000, 1};
    tbl[3]  = '{"jr", 0, 5'b01000, '0, 32'd9,
                32'h1234, 0, 32'h40, 0,
                1, 1, 32'h0000_1234, 1};
    tbl[4]  = '{"beq_flush", 1, 5'b10001, '0, 32'd4,
                32'd2, 32'd2, 32'h308, 0,
                0, 0, 32'h0, 0};
    tbl[5]  = '{"bad_op", 0, 5'b11111, '0, 32'd4,
                32'd2, 32'd2, 32'h30C, 0,
                0, 0, 32'h0, 0};
    tbl[6]  = '{"bne_back", 0, 5'b10010, '0,
                32'hFFFF_FFFC, 32'd5, 32'hFFFF_FFFD,
                32'h1000, 0, 1, 1, 32'h0000_0FF0, 1};
    tbl[7]  = '{"bgez_zero", 0, 5'b00010, '0, 32'd1,
                0, 0, 32'h2000, 1,
                1, 1, 32'h0000_2004, 0};
    tbl[8]  = '{"bgtz_zero", 0, 5'b00011, '0, 32'd1,
                0, 0, 32'h2000, 0,
                1, 0, 32'h0000_2004, 0};
    tbl[9]  = '{"bal", 0, 5'b00001, '0, 32'h10,
                0, 0, 32'h3000, 0,
                1, 1, 32'h0000_3040, 1};
    tbl[10] = '{"beq_nt", 0, 5'b10001, '0, 32'd2,
                32'd7, 32'hFFFF_FFF9, 32'h40, 1,
                1, 0, 32'h0000_0044, 1};
    e_br  = 6;
    e_mis = 3;
    for (int i = 0; i < 11; i++) begin
      req(tbl[i].op, tbl[i].target, tbl[i].imm,
          tbl[i].d0, tbl[i].d1, tbl[i].pc,
          tbl[i].pred, tbl[i].flush);
      tick();
      chk_res(tbl[i].name, tbl[i].e_valid,
              tbl[i].e_taken, tbl[i].e_pc,
              tbl[i].e_redir);
    end
    idle();
    tick();
    chk_res("tbl.idle", 0, 0, 32'h0, 0);
    chk("tbl.br", br_count, 32'(e_br));
    chk("tbl.mis", mis_count, 32'(e_mis));
    // flushed BEQ and the J left their entries at 01
    if_pc = 32'h308;
    #1;
    chk("flush.bht", 32'(if_pred_taken), 0);
    if_pc = 32'h10;
    #1;
    chk("j.bht", 32'(if_pred_taken), 0);
    // entry 0 trained T,T,N from 01 -> 10
    if_pc = 32'h0;
    #1;
    chk("idx0.bht", 32'(if_pred_taken), 1);

    // Mid-stream reset with a request presented
    req(5'b10001, '0, 32'd4, 32'd1, 32'd1,
        32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    chk_res("mrst", 0, 0, 32'h0, 0);
    chk("mrst.br", br_count, 0);
    chk("mrst.mis", mis_count, 0);
    pcs[0] = 32'h0;
    pcs[1] = 32'h2000;
    pcs[2] = 32'h1C;
    for (int i = 0; i < 3; i++) begin
      if_pc = pcs[i];
      #1;
      exp_p = 1'b0;
      chk($sformatf("mrst.bht%0d", i),
          32'(if_pred_taken), 32'(exp_p));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
